rpn_sequenciador_etapas: RTL



---
 rtl/rpn_sequenciador_etapas_pkg.sv | 16 +
 rtl/rpn_sequenciador_etapas_if.sv | 14 +
 rtl/rpn_sequenciador_etapas_botao_pulso.sv | 83 ++++++++
 rtl/rpn_sequenciador_etapas.sv | 104 ++++++++++
 4 files changed

// File: rtl/rpn_sequenciador_etapas_pkg.sv
// Shared definitions for the RPN ALU step sequencer: step encodings and a counter sizing helper.
package rpn_pkg;

    typedef enum logic [1:0] {
        ETAPA_A    = 2'b00,
        ETAPA_B    = 2'b01,
        ETAPA_OP   = 2'b10,
        ETAPA_EXEC = 2'b11
    } etapa_t;

    // Bits needed to hold a count running from 0 to maxCount-1 (never less than one bit).
    function automatic int cntWidth(input int maxCount);
        return (maxCount <= 2) ? 1 : $clog2(maxCount);
    endfunction

endpackage

// File: rtl/rpn_sequenciador_etapas_if.sv
// Step code and strobe bundle from the step sequencer to the RPN stack/mux-select stage.
interface rpn_sequenciador_etapas_if;

    logic [1:0] Etapa;
    logic       LoadA;
    logic       LoadB;
    logic       LoadOp;
    logic       LoadResultado;
    logic       Reset_borda;

    modport master (output Etapa, LoadA, LoadB, LoadOp, LoadResultado, Reset_borda);
    modport slave  (input  Etapa, LoadA, LoadB, LoadOp, LoadResultado, Reset_borda);

endinterface

// File: rtl/rpn_sequenciador_etapas_botao_pulso.sv
// Push-button conditioner: 2-FF synchroniser, optional debounce (RPN_DEBOUNCE_EN), registered press pulse.
module rpn_botao_pulso
`ifdef RPN_DEBOUNCE_EN
#(
    parameter int DEBOUNCE_CYCLES = 1000000
)
`endif
(
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic pulse_o
);

    logic sync1_q;
    logic sync2_q;
    logic level_q;
    logic pulse_q;
    logic condLevel;

    // Synchroniser flops reset to the released (high) level of the active-low key.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
        end
    end

`ifdef RPN_DEBOUNCE_EN
    import rpn_pkg::*;

    localparam int DW = cntWidth(DEBOUNCE_CYCLES);

    logic [DW-1:0] deb_q;
    logic [DW-1:0] deb_d;
    logic          debLevel_q;
    logic          debLevel_d;

    // Any sample agreeing with the accepted level restarts the count, so bounces never accumulate.
    always_comb begin
        deb_d      = '0;
        debLevel_d = debLevel_q;
        if (sync2_q != debLevel_q) begin
            if (deb_q == DW'(DEBOUNCE_CYCLES - 1)) begin
                debLevel_d = sync2_q;
            end else begin
                deb_d = deb_q + DW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb_q      <= '0;
            debLevel_q <= 1'b1;
        end else begin
            deb_q      <= deb_d;
            debLevel_q <= debLevel_d;
        end
    end

    assign condLevel = debLevel_q;
`else
    assign condLevel = sync2_q;
`endif

    // Stored level resets high so releasing reset with the key idle never produces a pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q <= 1'b1;
            pulse_q <= 1'b0;
        end else begin
            level_q <= condLevel;
            pulse_q <= level_q & ~condLevel;
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/rpn_sequenciador_etapas.sv
// RPN ALU step sequencer: ENTER/CLEAR keys -> Etapa, load strobes, LoadResultado and Reset_borda.
// Defining RPN_DEBOUNCE_EN adds a DEBOUNCE_CYCLES debounce filter on both keys.
module rpn_sequenciador_etapas
    import rpn_pkg::*;
#(
    parameter int EXEC_CYCLES = 2
`ifdef RPN_DEBOUNCE_EN
    , parameter int DEBOUNCE_CYCLES = 1000000
`endif
) (
    input  logic                             CLOCK,
    input  logic                             RESET_N,
    input  logic                             BTN_ENTER,
    input  logic                             BTN_CLEAR,
    rpn_sequenciador_etapas_if.master        bus
);

    localparam int CW = cntWidth(EXEC_CYCLES);

    etapa_t        state_q;
    etapa_t        state_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          resetBorda_q;
    logic          enterP;
    logic          clearP;
    logic          terminal;

`ifdef RPN_DEBOUNCE_EN
    rpn_botao_pulso #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) uEnter (
        .clk(CLOCK), .rst_n(RESET_N), .btn_i(BTN_ENTER), .pulse_o(enterP));
    rpn_botao_pulso #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) uClear (
        .clk(CLOCK), .rst_n(RESET_N), .btn_i(BTN_CLEAR), .pulse_o(clearP));
`else
    rpn_botao_pulso uEnter (.clk(CLOCK), .rst_n(RESET_N), .btn_i(BTN_ENTER), .pulse_o(enterP));
    rpn_botao_pulso uClear (.clk(CLOCK), .rst_n(RESET_N), .btn_i(BTN_CLEAR), .pulse_o(clearP));
`endif

    // resetBorda_q doubles as the power-on clear flop: it resets high and then just follows clearP.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q      <= ETAPA_A;
            cnt_q        <= '0;
            resetBorda_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            resetBorda_q <= clearP;
        end
    end

    assign terminal = (cnt_q == CW'(EXEC_CYCLES - 1));

    // CLEAR beats ENTER; during the clear pulse itself the step is held so no press is half-taken.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (clearP) begin
            state_d = ETAPA_A;
            cnt_d   = '0;
        end else if (!resetBorda_q) begin
            case (state_q)
                ETAPA_A:    if (enterP) state_d = ETAPA_B;
                ETAPA_B:    if (enterP) state_d = ETAPA_OP;
                ETAPA_OP: begin
                    if (enterP) begin
                        state_d = ETAPA_EXEC;
                        cnt_d   = '0;
                    end
                end
                ETAPA_EXEC: begin
                    if (terminal) begin
                        state_d = ETAPA_A;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default:    state_d = ETAPA_A;
            endcase
        end
    end

    // Strobes decode the current step, so Etapa still shows the issuing step while they are high.
    always_comb begin
        bus.LoadA         = 1'b0;
        bus.LoadB         = 1'b0;
        bus.LoadOp        = 1'b0;
        bus.LoadResultado = 1'b0;
        if (!clearP && !resetBorda_q) begin
            case (state_q)
                ETAPA_A:    bus.LoadA         = enterP;
                ETAPA_B:    bus.LoadB         = enterP;
                ETAPA_OP:   bus.LoadOp        = enterP;
                ETAPA_EXEC: bus.LoadResultado = terminal;
                default:    bus.LoadA         = 1'b0;
            endcase
        end
    end

    assign bus.Etapa       = state_q;
    assign bus.Reset_borda = resetBorda_q;

endmodule
